// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared FSM states, funct3 codes, bus size codes and request legality check
package load_store_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {EXC_NONE, EXC_ILLEGAL, EXC_MISALIGNED, EXC_TIMEOUT} exc_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  function automatic logic req_illegal(input logic load, input logic store, input logic [2:0] f3);
    return (load == store) || (load ? (f3[1:0] == 2'b11 || f3 == 3'b110) : (f3[2] || f3[1:0] == 2'b11));
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: funct3-driven alignment check (addr_lo) and load-data sign/zero extension (data -> ext_data)
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic        misaligned,
  output logic [31:0] ext_data
);
  assign misaligned = (funct3[1:0] == SZ_H && addr_lo[0]) || (funct3[1:0] == SZ_W && addr_lo != 2'b00);
  always_comb
    ext_data = funct3 == F3_B  ? {{24{data[7]}}, data[7:0]} :
               funct3 == F3_H  ? {{16{data[15]}}, data[15:0]} :
               funct3 == F3_BU ? {24'b0, data[7:0]} :
               funct3 == F3_HU ? {16'b0, data[15:0]} : data;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding load/store initiator; req_* in, bus_* strobes out, single-cycle resp_*/exc_* out
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [31:0] bus_addr_out,
  output logic [1:0]  bus_size_out,
  output logic [31:0] bus_addr_in,
  output logic [1:0]  bus_size_in,
  output logic [31:0] bus_data_in,
  input  logic [31:0] bus_data_out,
  input  logic        bus_busy,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        exc_misaligned,
  output logic        exc_illegal,
  output logic        exc_bus_timeout,
  output logic [31:0] exc_addr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + READ_LATENCY + 1);
  state_e state_q, state_d;
  exc_e exc_q, exc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ea_q, ea_d, wdata_q, wdata_d, rdata_q, rdata_d, req_ea, ext_data;
  logic [2:0] f3_q, f3_d, f3_sel;
  logic [4:0] rd_q, rd_d;
  logic load_q, load_d, misaligned, in_resp;
  assign req_ea = req_base + req_offset;
  // In IDLE the extender checks the incoming request; afterwards it extends the captured read data.
  assign f3_sel = state_q == S_IDLE ? req_funct3 : f3_q;
  lsu_extend u_ext (
    .funct3    (f3_sel),
    .addr_lo   (req_ea[1:0]),
    .data      (rdata_q),
    .misaligned(misaligned),
    .ext_data  (ext_data)
  );
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    load_d  = load_q;
    case (state_q)
      S_IDLE:
        if (req_valid) begin
          ea_d    = req_ea;
          f3_d    = req_funct3;
          rd_d    = req_rd;
          wdata_d = req_wdata;
          load_d  = req_load;
          cnt_d   = '0;
          exc_d   = req_illegal(req_load, req_store, req_funct3) ? EXC_ILLEGAL :
                    misaligned ? EXC_MISALIGNED : EXC_NONE;
          state_d = exc_d == EXC_NONE ? S_ISSUE : S_RESP;
        end
      S_ISSUE:
        if (!bus_busy) begin
          state_d = load_q ? S_WAIT : S_RESP;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          exc_d   = EXC_TIMEOUT;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      S_WAIT:
        if (cnt_q == CW'(READ_LATENCY - 1)) begin
          rdata_d = bus_data_out;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      exc_q   <= EXC_NONE;
      cnt_q   <= '0;
      ea_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
      ea_q    <= ea_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
    end
  end
  assign req_ready       = state_q == S_IDLE;
  assign bus_rd          = load_q && (state_q == S_ISSUE || state_q == S_WAIT);
  assign bus_wd          = !load_q && state_q == S_ISSUE;
  assign bus_addr_out    = bus_rd ? ea_q : '0;
  assign bus_size_out    = bus_rd ? f3_q[1:0] : '0;
  assign bus_addr_in     = bus_wd ? ea_q : '0;
  assign bus_size_in     = bus_wd ? f3_q[1:0] : '0;
  assign bus_data_in     = bus_wd ? wdata_q : '0;
  assign in_resp         = state_q == S_RESP;
  assign resp_valid      = in_resp;
  assign resp_we         = in_resp && load_q && exc_q == EXC_NONE;
  assign resp_data       = resp_we ? ext_data : '0;
  assign resp_rd         = in_resp ? rd_q : '0;
  assign exc_addr        = in_resp ? ea_q : '0;
  assign exc_illegal     = in_resp && exc_q == EXC_ILLEGAL;
  assign exc_misaligned  = in_resp && exc_q == EXC_MISALIGNED;
  assign exc_bus_timeout = in_resp && exc_q == EXC_TIMEOUT;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store requests checked against a behavioural reference model
module tb_load_store_unit;
  localparam int T  = 16;
  localparam int RL = 1;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, bus_busy = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0, bus_data_out = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, bus_rd, bus_wd, resp_valid, resp_we, exc_misaligned, exc_illegal, exc_bus_timeout;
  logic [31:0] bus_addr_out, bus_addr_in, bus_data_in, resp_data, exc_addr;
  logic [1:0] bus_size_out, bus_size_in;
  logic [4:0] resp_rd;
  int checks = 0, errors = 0;
  load_store_unit #(.TIMEOUT_CYCLES(T), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .bus_rd(bus_rd), .bus_wd(bus_wd),
    .bus_addr_out(bus_addr_out), .bus_size_out(bus_size_out), .bus_addr_in(bus_addr_in),
    .bus_size_in(bus_size_in), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_busy(bus_busy), .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal),
    .exc_bus_timeout(exc_bus_timeout), .exc_addr(exc_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0: return 32'($signed(d[7:0]));
      3'd1: return 32'($signed(d[15:0]));
      3'd4: return 32'(d[7:0]);
      3'd5: return 32'(d[15:0]);
      default: return d;
    endcase
  endfunction
  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                        input int busy_n, input logic [31:0] raw);
    logic [31:0] ea, bdata, exp_data;
    int bytes, nstrobe, n, k;
    bit ill, mis, to, done;
    ea    = base + off;
    ill   = (ld == st) || (ld && (f3 == 3 || f3 >= 6)) || (st && f3 > 2);
    bytes = 1 << f3[1:0];
    mis   = !ill && (ea % bytes) != 0;
    to    = !ill && !mis && busy_n >= T;
    nstrobe = (ill || mis) ? 0 : to ? T : busy_n + 1 + (ld ? RL : 0);
    bdata = bytes == 1 ? {24'b0, raw[7:0]} : bytes == 2 ? {16'b0, raw[15:0]} : raw;
    exp_data = (ld && !ill && !mis && !to) ? model_load(f3, bdata) : 32'd0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd; bus_busy = 1'b0;
    @(posedge clk);
    n = 0; k = 0; done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b0; req_base = $urandom; req_offset = $urandom; req_wdata = $urandom;
        req_rd = 5'($urandom); req_funct3 = 3'($urandom);
      end
      n++;
      if (resp_valid) done = 1;
      else if (bus_rd || bus_wd) begin
        k++;
        if (ld) begin
          chk("rd_addr", bus_addr_out, ea);
          chk("rd_size", {30'b0, bus_size_out}, f3[1:0]);
          chk("rd_other_side", {bus_wd, bus_addr_in[30:0]}, 32'd0);
        end else begin
          chk("wd_addr", bus_addr_in, ea);
          chk("wd_size", {30'b0, bus_size_in}, f3[1:0]);
          chk("wd_data", bus_data_in, wd);
          chk("wd_other_side", {bus_rd, bus_addr_out[30:0]}, 32'd0);
        end
      end
      bus_busy = k >= 1 && k <= busy_n;
      bus_data_out = (k >= busy_n + 2) ? bdata : $urandom;
    end
    bus_busy = 1'b0;
    chk("resp_seen", {31'b0, done}, 32'd1);
    chk("strobe_cycles", k, nstrobe);
    chk("resp_latency", n, nstrobe + 1);
    chk("exc_bits", {29'b0, exc_illegal, exc_misaligned, exc_bus_timeout}, {29'b0, ill, mis, to});
    chk("exc_addr", exc_addr, ea);
    chk("resp_rd", {27'b0, resp_rd}, {27'b0, rd});
    chk("resp_we", {31'b0, resp_we}, {31'b0, ld && !ill && !mis && !to});
    chk("resp_data", resp_data, exp_data);
    @(negedge clk);
    chk("resp_one_cycle", {30'b0, resp_valid, req_ready}, 32'd1);
  endtask
  initial begin
    int hits;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_strobes", {29'b0, bus_rd, bus_wd, resp_valid}, 32'd0);
    chk("reset_outs", bus_addr_out | bus_addr_in | bus_data_in | resp_data | exc_addr, 32'd0);
    chk("reset_exc", {28'b0, resp_we, exc_illegal, exc_misaligned, exc_bus_timeout}, 32'd0);
    do_req(1, 0, 3'd2, 32'h100, 32'd4, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    do_req(1, 0, 3'd0, 32'h200, 32'd0, 32'h0, 5'd4, 0, 32'h00000080);
    do_req(1, 0, 3'd4, 32'h200, 32'd0, 32'h0, 5'd5, 0, 32'h00000080);
    do_req(1, 0, 3'd1, 32'h202, 32'd0, 32'h0, 5'd6, 1, 32'h00008001);
    do_req(1, 0, 3'd5, 32'h202, 32'd0, 32'h0, 5'd7, 2, 32'h0000F00D);
    do_req(0, 1, 3'd1, 32'h300, 32'hFFFFFFFF, 32'h5555, 5'd8, 0, 32'h0);
    do_req(0, 1, 3'd2, 32'h10, 32'd0, 32'h12345678, 5'd9, 3, 32'h0);
    do_req(0, 1, 3'd2, 32'h20, 32'd0, 32'hCAFEF00D, 5'd10, 100, 32'h0);
    do_req(1, 0, 3'd2, 32'h40, 32'd0, 32'h0, 5'd11, T - 1, 32'h87654321);
    do_req(1, 1, 3'd2, 32'h40, 32'd0, 32'h0, 5'd12, 0, 32'h0);
    do_req(0, 0, 3'd0, 32'h40, 32'd0, 32'h0, 5'd13, 0, 32'h0);
    do_req(0, 1, 3'd4, 32'h41, 32'd0, 32'h0, 5'd14, 0, 32'h0);
    do_req(1, 0, 3'd2, 32'h42, 32'd0, 32'h0, 5'd15, 0, 32'h0);
    do_req(1, 0, 3'd1, 32'hFFFFFFFF, 32'd3, 32'h0, 5'd16, 0, 32'h0000ABCD);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
    req_base = 32'h500; req_offset = 32'd0; bus_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_bus_rd", {31'b0, bus_rd}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_strobe", {30'b0, bus_rd, resp_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      hits += int'(resp_valid);
    end
    chk("rst_no_resp", hits, 0);
    for (int i = 0; i < 60; i++) begin
      bit ld, st;
      int b;
      logic [31:0] base;
      ld = $urandom_range(0, 1) == 1;
      st = $urandom_range(0, 9) == 0 ? ld : !ld;
      base = $urandom;
      if ($urandom_range(0, 2) != 0) base[1:0] = 2'b00;
      b = $urandom_range(0, 9) == 0 ? T + $urandom_range(0, 3) : $urandom_range(0, 3);
      do_req(ld, st, 3'($urandom), base, 32'($signed(12'($urandom))) & ~32'd3, $urandom,
             5'($urandom), b, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
